// File: rtl/fdc_multi_core.sv
`timescale 1ns/1ps
// fdc_multi_core
// Multi-channel frequency-to-digital converter. Counts rising edges of CH
// asynchronous VCO inputs over a window of gate_len reference-clock periods
// (0 treated as 1), latches per-channel results with saturation flags and
// presents the selected channel on count_out/overflow.
//
// Ports
//   clk         system clock
//   rst_n       async active-low reset
//   clk_ref_in  async reference clock (window timebase)
//   vco_in      async VCO inputs, one per channel
//   start       level, sampled only in IDLE
//   continuous  1 = re-arm back-to-back windows
//   gate_len    window length in reference periods
//   sel         channel select for count_out/overflow
//   busy        high in ARM and GATE
//   valid       one-cycle pulse when new results are latched
//   count_out   latched count of channel sel (0 if sel >= CH)
//   overflow    latched saturation flag of channel sel
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; gate_len captured on start
// ARM   | waiting for the first reference edge, which opens the window
// GATE  | counting; reference edge with ref_cnt == gate_q closes window

module fdc_multi_core #(
  parameter int CH          = 2,
  parameter int CNT_W       = 12,
  parameter int GATE_W      = 4,
  parameter int SYNC_STAGES = 2,
  localparam int SEL_W      = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_ref_in,
  input  logic [CH-1:0]     vco_in,
  input  logic              start,
  input  logic              continuous,
  input  logic [GATE_W-1:0] gate_len,
  input  logic [SEL_W-1:0]  sel,
  output logic              busy,
  output logic              valid,
  output logic [CNT_W-1:0]  count_out,
  output logic              overflow
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_GATE} state_t;

  // bit 0 is the reference clock, bits CH:1 are the VCO channels
  localparam int NIN = CH + 1;

  logic [NIN-1:0]    w_async;
  logic [NIN-1:0]    r_sync [SYNC_STAGES];
  logic [NIN-1:0]    r_hist;
  logic [NIN-1:0]    w_rise;
  logic              w_ref_rise;
  logic [CH-1:0]     w_vco_rise;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_open;
  logic              w_close;
  logic              w_load_gate;

  logic [GATE_W-1:0] r_gate_q;
  logic [GATE_W-1:0] r_ref_cnt;
  logic              r_valid;
  logic [CNT_W-1:0]  r_cnt [CH];
  logic [CH-1:0]     r_sat;
  logic [CNT_W-1:0]  r_res [CH];
  logic [CH-1:0]     r_ovf;

  assign w_async    = {vco_in, clk_ref_in};
  assign w_rise     = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign w_ref_rise = w_rise[0];
  assign w_vco_rise = w_rise[CH:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
      r_hist <= '0;
    end else begin
      r_sync[0] <= w_async;
      for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_open      = 1'b0;
    w_close     = 1'b0;
    w_load_gate = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_ARM;
          w_load_gate = 1'b1;
        end
      end
      S_ARM: begin
        if (w_ref_rise) begin
          w_state_nxt = S_GATE;
          w_open      = 1'b1;
        end
      end
      S_GATE: begin
        if (w_ref_rise && (r_ref_cnt == r_gate_q)) begin
          w_close = 1'b1;
          if (continuous) begin
            // closing edge doubles as the opening edge of the next window
            w_open      = 1'b1;
            w_load_gate = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gate_q  <= GATE_W'(1);
      r_ref_cnt <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= w_close;
      if (w_load_gate)
        r_gate_q <= (gate_len == '0) ? GATE_W'(1) : gate_len;
      if (w_open)
        r_ref_cnt <= GATE_W'(1);
      else if ((r_state == S_GATE) && w_ref_rise && !w_close)
        r_ref_cnt <= r_ref_cnt + GATE_W'(1);
    end
  end

  // A VCO edge in the closing cycle belongs to the next window (or nowhere):
  // the result copy takes the pre-edge count, and reopening reloads from it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH; i++) begin
        r_cnt[i] <= '0;
        r_res[i] <= '0;
      end
      r_sat <= '0;
      r_ovf <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (w_close) begin
          r_res[i] <= r_cnt[i];
          r_ovf[i] <= r_sat[i];
        end
        if (w_open) begin
          r_cnt[i] <= CNT_W'(w_vco_rise[i]);
          r_sat[i] <= 1'b0;
        end else if ((r_state == S_GATE) && !w_close && w_vco_rise[i]) begin
          // flag marks an edge that arrived with the counter already full
          if (&r_cnt[i]) r_sat[i] <= 1'b1;
          else           r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    count_out = '0;
    overflow  = 1'b0;
    for (int i = 0; i < CH; i++) begin
      if (sel == SEL_W'(i)) begin
        count_out = r_res[i];
        overflow  = r_ovf[i];
      end
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign valid = r_valid;

endmodule
